// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader and its storage:
//   the loader state enum, the default store depth and the word width.
//   No ports; imported by the interface, the storage array and the loader.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int XLEN        = 32;  // instruction word width
    localparam int IMEM_DEPTH  = 64;  // default number of words (PC[7:2])

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // no program present, core held in reset
        LOAD  = 2'd1,  // byte stream being packed into the store
        RUN   = 2'd2   // program present, core released
    } loaderState_t;

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Groups the loader's control, byte-stream and fetch signals.
//   master : the side that starts loads, streams bytes and fetches words
//   slave  : the loader itself
//   Signals: load_start/load_len (session request), byte_valid/byte_data/
//   byte_ready (byte stream), rd_addr/rd_data (fetch port), core_rst, busy,
//   done, err (status) and dbgState (current loader state, for observation).
//
//   Byte handshake: a byte moves exactly on a rising edge where byte_valid
//   and byte_ready are both high; byte_valid may drop at any time and
//   byte_ready does not depend on byte_valid.
// ---------------------------------------------------------------------------
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) ();

    logic               load_start;
    logic [ADDR_W:0]    load_len;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic [ADDR_W-1:0]  rd_addr;
    logic [XLEN-1:0]    rd_data;
    logic               core_rst;
    logic               busy;
    logic               done;
    logic               err;
    loaderState_t       dbgState;

    modport master (
        output load_start, load_len, byte_valid, byte_data, rd_addr,
        input  byte_ready, rd_data, core_rst, busy, done, err, dbgState
    );

    modport slave (
        input  load_start, load_len, byte_valid, byte_data, rd_addr,
        output byte_ready, rd_data, core_rst, busy, done, err, dbgState
    );

endinterface

// File: rtl/imem_loader_array.sv
// ---------------------------------------------------------------------------
// imem_array
//   DEPTH x WIDTH word store with one synchronous write port and one
//   asynchronous read port. Contents are never reset or cleared.
//   Ports: clk, we/waddr/wdata (write on rising edge), raddr/rdata (comb read).
// ---------------------------------------------------------------------------
module imem_array
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 6,
    parameter int WIDTH  = XLEN
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Packs a little-endian byte stream into 32-bit words, writes them into the
//   instruction store and holds the core in reset until a whole program has
//   been loaded.
//   Ports: clk, rst (synchronous, active-high), bus (imem_loader_if.slave:
//   load request, byte stream, fetch port, core_rst/busy/done/err, dbgState).
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    loaderState_t       state;
    loaderState_t       nextState;
    logic [1:0]         byteCnt;
    logic [ADDR_W-1:0]  wordPtr;
    logic [ADDR_W:0]    lenLatch;
    logic [23:0]        asmReg;     // lanes 0..2; lane 3 goes straight to memory
    logic               doneQ;
    logic               errQ;

    logic lenLegal;
    logic startOk;
    logic startBad;
    logic byteTake;
    logic wordDone;
    logic lastByte;

    // load_start is only looked at outside LOAD, so a request during a
    // session neither restarts it nor raises err.
    always_comb begin
        lenLegal = (bus.load_len != '0) && (bus.load_len <= MAX_LEN);
        startOk  = bus.load_start && (state != LOAD) && lenLegal;
        startBad = bus.load_start && (state != LOAD) && !lenLegal;
        byteTake = bus.byte_valid && (state == LOAD);
        wordDone = byteTake && (byteCnt == 2'd3);
        lastByte = wordDone && ({1'b0, wordPtr} == (lenLatch - (ADDR_W+1)'(1)));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            EMPTY, RUN: if (startOk)  nextState = LOAD;
            LOAD:       if (lastByte) nextState = RUN;
            default:    nextState = EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        bus.byte_ready = (state == LOAD);
        bus.busy       = (state == LOAD);
        bus.core_rst   = (state != RUN);
        bus.done       = doneQ;
        bus.err        = errQ;
        bus.dbgState   = state;
    end

    // Counters, assembly register and one-cycle status pulses.
    // Clearing byteCnt on reset is what discards a half-built word.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteCnt  <= '0;
            wordPtr  <= '0;
            lenLatch <= '0;
            asmReg   <= '0;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            doneQ <= lastByte;
            errQ  <= startBad;
            if (startOk) begin
                byteCnt  <= '0;
                wordPtr  <= '0;
                lenLatch <= bus.load_len;
            end else if (byteTake) begin
                byteCnt <= byteCnt + 2'd1;
                case (byteCnt)
                    2'd0:    asmReg[7:0]   <= bus.byte_data;
                    2'd1:    asmReg[15:8]  <= bus.byte_data;
                    2'd2:    asmReg[23:16] <= bus.byte_data;
                    default: wordPtr       <= wordPtr + ADDR_W'(1);
                endcase
            end
        end
    end

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (XLEN)
    ) u_array (
        .clk   (clk),
        .we    (wordDone),
        .waddr (wordPtr),
        .wdata ({bus.byte_data, asmReg}),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

endmodule
